out_buf: RTL and testbench
==========================

# out_buf

Double-banked output buffer between `out_ctrl` (accumulator read-out) and the `batch_ctrl` destination read path.
- Write side: takes each accumulator word strobed by `outr` at address `oa`, rescales it, optionally applies ReLU, saturates it, and writes it into the current fill bank.
- Bank handoff: `outrf` closes the fill bank and hands it to the read side.
- Read side: `batch_ctrl` drains the bank with `dst_v`/`dst_a`, then releases it with `dst_last`.

## Interface
- `DW`, 32: accumulator input width, signed
- `OW`, 16: output word width, signed
- `AW`, 10: address width, matching `oa`
- `DEPTH`, 1024: words per bank, at most 2^AW
- `FRAC`, 8: fractional bits removed by the arithmetic right shift, 0..DW-1
- `clk`  in  1  clock; everything is on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `run`  in  1  0 = synchronous clear of bank state and pipeline, same effect as reset except memory and sticky flags
- `relu`  in  1  1 = negative results are written as 0
- `outr`  in  1  write strobe from `out_ctrl`
- `outrf`  in  1  qualified by `outr`; marks the final write of the bank
- `oa`  in  AW  write address within the bank
- `acc`  in  DW  accumulator data, aligned with `outr`
- `dst_v`  in  1  read strobe
- `dst_a`  in  AW  read address
- `dst_last`  in  1  qualified by `dst_v`; marks the final read of the bank
- `dst_d`  out  OW  read data, reset 0
- `dst_dv`  out  1  read data valid, reset 0
- `wr_ready`  out  1  fill bank is EMPTY or FILL, reset 1
- `rd_ready`  out  1  read bank is FULL or DRAIN, reset 0
- `wr_bank`, `rd_bank`  out  1 each  bank pointers, reset 0
- `ovf`  out  1  sticky; set when saturation clipped a value; reset 0
- `err`  out  1  sticky; set on a write or read to a bank in the wrong state; reset 0

## Operation
- Each bank has one state: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY.
- EMPTY->FILL: first `outr` that targets `wr_bank`.
- FILL->FULL: the `outr&outrf` write commits; `wr_bank` toggles in the same cycle.
- FULL->DRAIN: first `dst_v` to `rd_bank`.
- DRAIN->EMPTY: `dst_v&dst_last`; `rd_bank` toggles.
- A bank can take `outr&outrf` straight from EMPTY. It commits to FULL after its single write.
- Commit and release on different banks in the same cycle: both transitions happen.
- `outr` while the fill bank is FULL or DRAIN: the write is dropped and `err` is set. Bank state does not change.
- `dst_v` while the read bank is EMPTY or FILL: `dst_d`=0, `dst_dv`=1, `err` is set, no transition.
- Arithmetic, computed in DW+1 bits:
  - t = (acc + (FRAC ? 2^(FRAC-1) : 0)) >>> FRAC, i.e. round half up.
  - Saturate t to [-2^(OW-1), 2^(OW-1)-1]. Any clip sets `ovf`.
  - Then, if `relu`=1, a negative result becomes 0.
- Memory is 2*DEPTH words addressed by {bank, addr}. `oa` and `dst_a` values >= DEPTH wrap modulo DEPTH.
- `err` and `ovf` clear only on `reset`. Memory contents are never cleared.

## Timing
- Write pipeline:
  - Stage 1 registers `acc`, `oa`, `outr`, `outrf`, `relu` and the target bank, then rounds and shifts.
  - Stage 2 saturates, applies ReLU and writes memory at the second edge after `outr`.
- The bank is chosen at stage 1. FILL->FULL, the `wr_bank` toggle and `rd_ready` rising happen at the stage-2 write edge.
- Back-to-back `outr` every cycle is supported. A new bank's first write may follow the `outrf` write in the very next cycle.
- Read: `dst_d`/`dst_dv` are registered and appear 1 cycle after `dst_v`. Throughput is 1 word per cycle.
- The FULL bank becomes readable (`rd_ready`=1) in the cycle after its last write edge. There is no read-during-write hazard, because reads and writes always hit different banks.
- The `wr_ready` deassertion is seen by `out_ctrl` 1 cycle after the commit. Upstream must keep 2 pipeline writes of slack.
- Reset mid-operation: all state and outputs return to reset values immediately. A stage-1 write in flight is discarded.

## Structure
- Package `out_buf_pkg`:
  - `bank_state_t` enum: EMPTY, FILL, FULL, DRAIN.
  - Function `sat_round`, parameterised by widths via arguments.
  - Localparam for the round constant.
- Sub-module `dp_ram`: simple dual-port RAM, one write port, one registered read port, depth 2*DEPTH, width OW.
- Top level holds: the two bank FSMs, the pointers, the 2-stage write pipe and the flags.

## Test plan
- FRAC=8, relu=0:
  - `acc`=384 -> stored 2.
  - `acc`=-384 -> stored -1.
  - `acc`=0x7FFFFFFF -> stored 32767, `ovf`=1.
- relu=1, `acc`=-384 -> stored 0, `ovf` stays 0.
- Fill bank 0 with 20 writes, the last with `outrf` -> `rd_ready`=1 three edges after that `outr`, `wr_bank`=1. Read `dst_a`=0..19 returns the written values 1 cycle later; `dst_last` -> `rd_bank`=1, bank 0 EMPTY.
- Fill both banks without reading -> `wr_ready`=0. Then one extra `outr` -> `err`=1, no data corrupted in either bank.
- Commit bank 1 in the same cycle as `dst_last` on bank 0 -> bank 0 EMPTY, bank 1 FULL, `rd_bank`=1, `wr_bank`=0, `wr_ready`=1.
- Drop `reset` in the middle of draining bank 0 -> all outputs return to reset values; the next fill starts in bank 0.

Source files
------------

// File: rtl/out_buf_pkg.sv
// Shared types and arithmetic helpers for the double-banked output buffer.
package out_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_t;

  // Working width for the saturation helper; covers any DW+1 up to 64 bits.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] val;
    logic                    clip;
  } sat_t;

  // Half-LSB constant added before the right shift (round half up).
  function automatic logic [SAT_W-1:0] round_const(input int frac);
    logic [SAT_W-1:0] r;
    r = '0;
    if (frac > 0) r[frac-1] = 1'b1;
    return r;
  endfunction

  // Clamp a rounded value into a signed ow-bit range and report clipping.
  function automatic sat_t sat_round(input logic signed [SAT_W-1:0] t, input int ow);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t res;
    hi = $signed((SAT_W'(1) << (ow - 1)) - SAT_W'(1));
    lo = -hi - SAT_W'(1);
    res.val  = t;
    res.clip = 1'b0;
    if (t > hi) begin
      res.val  = hi;
      res.clip = 1'b1;
    end else if (t < lo) begin
      res.val  = lo;
      res.clip = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/out_buf_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
module dp_ram #(
  parameter int W     = 16,
  parameter int N     = 2048,
  parameter int ABITS = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/out_buf.sv
// Double-banked output buffer: 2-stage rescale/saturate write pipe, per-bank
// EMPTY/FILL/FULL/DRAIN state, registered read port toward the destination.
module out_buf
  import out_buf_pkg::*;
#(
  parameter int DW    = 32,
  parameter int OW    = 16,
  parameter int AW    = 10,
  parameter int DEPTH = 1024,
  parameter int FRAC  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          relu,
  input  logic          outr,
  input  logic          outrf,
  input  logic [AW-1:0] oa,
  input  logic [DW-1:0] acc,
  input  logic          dst_v,
  input  logic [AW-1:0] dst_a,
  input  logic          dst_last,
  output logic [OW-1:0] dst_d,
  output logic          dst_dv,
  output logic          wr_ready,
  output logic          rd_ready,
  output logic          wr_bank,
  output logic          rd_bank,
  output logic          ovf,
  output logic          err
);

  localparam int RAW = $clog2(2 * DEPTH);
  localparam logic signed [DW:0] RND = $signed((DW+1)'(round_const(FRAC)));

  logic                 s1_valid_reg, s1_last_reg, s1_relu_reg, s1_bank_reg;
  logic [AW-1:0]        s1_addr_reg;
  logic signed [DW-1:0] s1_acc_reg;
  logic                 s2_valid_reg, s2_last_reg, s2_relu_reg, s2_bank_reg;
  logic [AW-1:0]        s2_addr_reg;
  logic signed [DW:0]   s2_t_reg;

  bank_state_t st_reg [2];
  bank_state_t st_next [2];
  logic        wr_bank_reg, wr_bank_next, rd_bank_reg, rd_bank_next;
  logic        ovf_reg, err_reg, dst_dv_reg, rd_ok_reg;
  logic        mem_we, rd_en, wr_err, rd_err;
  logic [1:0]  bank_writable, bank_readable;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_writable[gi] = (st_reg[gi] == EMPTY) || (st_reg[gi] == FILL);
    assign bank_readable[gi] = (st_reg[gi] == FULL) || (st_reg[gi] == DRAIN);
  end

  // Stage 1 arithmetic: sign-extend, add half LSB, arithmetic shift.
  logic signed [DW:0] s1_sum, s1_t;
  assign s1_sum = {s1_acc_reg[DW-1], s1_acc_reg} + RND;
  assign s1_t   = s1_sum >>> FRAC;

  // Commits still in the pipe decide which bank a new write belongs to.
  logic tgt_bank;
  assign tgt_bank = wr_bank_reg ^ (s1_valid_reg & s1_last_reg) ^ (s2_valid_reg & s2_last_reg);

  sat_t          s2_sat;
  logic [OW-1:0] s2_word_sat, s2_word;
  logic          sat_unused;
  assign s2_sat      = sat_round(SAT_W'(s2_t_reg), OW);
  assign s2_word_sat = s2_sat.val[OW-1:0];
  assign s2_word     = (s2_relu_reg && s2_word_sat[OW-1]) ? '0 : s2_word_sat;
  assign sat_unused  = &{1'b0, s2_sat.val[SAT_W-1:OW]};

  logic [RAW-1:0] wr_idx, rd_idx, ram_q_unused_idx;
  logic [OW-1:0]  ram_q;
  assign wr_idx = RAW'(s2_bank_reg) * RAW'(DEPTH) + RAW'(32'(s2_addr_reg) % DEPTH);
  assign rd_idx = RAW'(rd_bank_reg) * RAW'(DEPTH) + RAW'(32'(dst_a) % DEPTH);
  assign ram_q_unused_idx = '0;

  // Write and read never contend for one bank: writes need EMPTY/FILL, reads FULL/DRAIN.
  always_comb begin
    st_next[0]   = st_reg[0];
    st_next[1]   = st_reg[1];
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    mem_we       = 1'b0;
    rd_en        = 1'b0;
    wr_err       = 1'b0;
    rd_err       = 1'b0;
    if (run && s2_valid_reg) begin
      if (bank_writable[s2_bank_reg]) begin
        mem_we = 1'b1;
        st_next[s2_bank_reg] = s2_last_reg ? FULL : FILL;
        if (s2_last_reg) wr_bank_next = ~wr_bank_reg;
      end else begin
        wr_err = 1'b1;
      end
    end
    if (run && dst_v) begin
      if (bank_readable[rd_bank_reg]) begin
        rd_en = 1'b1;
        st_next[rd_bank_reg] = dst_last ? EMPTY : DRAIN;
        if (dst_last) rd_bank_next = ~rd_bank_reg;
      end else begin
        rd_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || !run) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_relu_reg  <= 1'b0;
      s1_bank_reg  <= 1'b0;
      s1_addr_reg  <= '0;
      s1_acc_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_relu_reg  <= 1'b0;
      s2_bank_reg  <= 1'b0;
      s2_addr_reg  <= '0;
      s2_t_reg     <= '0;
      st_reg[0]    <= EMPTY;
      st_reg[1]    <= EMPTY;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      dst_dv_reg   <= 1'b0;
      rd_ok_reg    <= 1'b0;
    end else begin
      s1_valid_reg <= outr;
      s1_last_reg  <= outr & outrf;
      s1_relu_reg  <= relu;
      s1_bank_reg  <= tgt_bank;
      s1_addr_reg  <= oa;
      s1_acc_reg   <= $signed(acc);
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
      s2_relu_reg  <= s1_relu_reg;
      s2_bank_reg  <= s1_bank_reg;
      s2_addr_reg  <= s1_addr_reg;
      s2_t_reg     <= s1_t;
      st_reg[0]    <= st_next[0];
      st_reg[1]    <= st_next[1];
      wr_bank_reg  <= wr_bank_next;
      rd_bank_reg  <= rd_bank_next;
      dst_dv_reg   <= dst_v;
      rd_ok_reg    <= rd_en;
    end
  end

  // Sticky flags survive run=0; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_reg <= 1'b0;
      err_reg <= 1'b0;
    end else if (run) begin
      if (s2_valid_reg && s2_sat.clip) ovf_reg <= 1'b1;
      if (wr_err || rd_err) err_reg <= 1'b1;
    end
  end

  dp_ram #(
    .W    (OW),
    .N    (2 * DEPTH),
    .ABITS(RAW)
  ) u_ram (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_idx | ram_q_unused_idx),
    .wdata(s2_word),
    .re   (rd_en),
    .raddr(rd_idx),
    .rdata(ram_q)
  );

  always_comb begin
    wr_ready = bank_writable[wr_bank_reg];
    rd_ready = bank_readable[rd_bank_reg];
    dst_d    = rd_ok_reg ? ram_q : '0;
  end

  assign dst_dv  = dst_dv_reg;
  assign wr_bank = wr_bank_reg;
  assign rd_bank = rd_bank_reg;
  assign ovf     = ovf_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_out_buf.sv
// Directed bench for out_buf: arithmetic vector table plus bank-handoff sequences.
module tb_out_buf;

  localparam int DW = 32, OW = 16, AW = 10, DEPTH = 1024, FRAC = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b1;
  logic          relu = 1'b0;
  logic          outr = 1'b0;
  logic          outrf = 1'b0;
  logic [AW-1:0] oa = '0;
  logic [DW-1:0] acc = '0;
  logic          dst_v = 1'b0;
  logic [AW-1:0] dst_a = '0;
  logic          dst_last = 1'b0;
  logic [OW-1:0] dst_d;
  logic          dst_dv, wr_ready, rd_ready, wr_bank, rd_bank, ovf, err;

  int checks = 0;
  int failures = 0;

  out_buf #(.DW(DW), .OW(OW), .AW(AW), .DEPTH(DEPTH), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .run(run), .relu(relu), .outr(outr), .outrf(outrf),
    .oa(oa), .acc(acc), .dst_v(dst_v), .dst_a(dst_a), .dst_last(dst_last),
    .dst_d(dst_d), .dst_dv(dst_dv), .wr_ready(wr_ready), .rd_ready(rd_ready),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic        relu;
    integer      val;
    logic        ovf;
  } vec_t;

  vec_t vt [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic integer pat(input int k);
    return k * 3 - 30;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dst_d"}, integer'(dst_d), 0);
    chk({tag, "_dst_dv"}, integer'(dst_dv), 0);
    chk({tag, "_wr_ready"}, integer'(wr_ready), 1);
    chk({tag, "_rd_ready"}, integer'(rd_ready), 0);
    chk({tag, "_wr_bank"}, integer'(wr_bank), 0);
    chk({tag, "_rd_bank"}, integer'(rd_bank), 0);
    chk({tag, "_ovf"}, integer'(ovf), 0);
    chk({tag, "_err"}, integer'(err), 0);
  endtask

  initial begin
    vt[0]  = '{32'sd384,          1'b0,      2, 1'b0};
    vt[1]  = '{-32'sd384,         1'b0,     -1, 1'b0};
    vt[2]  = '{-32'sd384,         1'b1,      0, 1'b0};
    vt[3]  = '{32'sd0,            1'b0,      0, 1'b0};
    vt[4]  = '{32'sd127,          1'b0,      0, 1'b0};
    vt[5]  = '{32'sd128,          1'b0,      1, 1'b0};
    vt[6]  = '{-32'sd128,         1'b0,      0, 1'b0};
    vt[7]  = '{-32'sd129,         1'b0,     -1, 1'b0};
    vt[8]  = '{32'sd8388479,      1'b0,  32767, 1'b0};
    vt[9]  = '{-32'sd8388608,     1'b0, -32768, 1'b0};
    vt[10] = '{32'sd384,          1'b1,      2, 1'b0};
    vt[11] = '{32'h7FFF_FFFF,     1'b0,  32767, 1'b1};
    vt[12] = '{-32'sd8388737,     1'b0, -32768, 1'b1};
    vt[13] = '{32'h8000_0000,     1'b1,      0, 1'b1};

    // Reset state
    tick();
    tick();
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Arithmetic table into bank 0, one write at a time so ovf can be tracked
    for (int i = 0; i < 14; i++) begin
      outr = 1'b1; oa = AW'(i); acc = vt[i].acc; relu = vt[i].relu;
      tick();
      outr = 1'b0; relu = 1'b0;
      tick();
      tick();
      chk($sformatf("ovf_v%0d", i), integer'(ovf), integer'(vt[i].ovf));
    end
    // Closing write with outrf: rd_ready rises on the third edge
    outr = 1'b1; outrf = 1'b1; oa = AW'(14); acc = '0;
    tick();
    outr = 1'b0; outrf = 1'b0;
    chk("rdy_edge1", integer'(rd_ready), 0);
    tick();
    chk("rdy_edge2", integer'(rd_ready), 0);
    tick();
    chk("rdy_edge3", integer'(rd_ready), 1);
    chk("wr_bank_after_commit0", integer'(wr_bank), 1);
    chk("wr_ready_bank1_empty", integer'(wr_ready), 1);
    for (int i = 0; i < 15; i++) begin
      dst_v = 1'b1; dst_a = AW'(i); dst_last = (i == 14);
      tick();
      chk($sformatf("rd_v%0d", i), $signed(dst_d), (i < 14) ? vt[i].val : 0);
    end
    dst_v = 1'b0; dst_last = 1'b0;
    chk("rd_dv_seen", integer'(dst_dv), 1);
    tick();
    chk("rd_bank_after_drain0", integer'(rd_bank), 1);
    chk("rd_ready_after_drain0", integer'(rd_ready), 0);
    chk("err_clean", integer'(err), 0);

    // 40 back-to-back writes: 20 into bank 1, then 20 into bank 0
    for (int k = 0; k < 40; k++) begin
      outr = 1'b1; outrf = (k == 19) || (k == 39);
      oa = AW'(k % 20); acc = 32'(pat(k) * 256);
      tick();
    end
    outr = 1'b0; outrf = 1'b0;
    tick();
    tick();
    chk("wr_ready_both_full", integer'(wr_ready), 0);
    chk("wr_bank_both_full", integer'(wr_bank), 1);
    chk("rd_ready_both_full", integer'(rd_ready), 1);
    outr = 1'b1; oa = AW'(5); acc = 32'h0050_0000;
    tick();
    outr = 1'b0;
    tick();
    tick();
    chk("err_write_full", integer'(err), 1);
    for (int i = 0; i < 20; i++) begin
      dst_v = 1'b1; dst_a = AW'(i); dst_last = (i == 19);
      tick();
      chk($sformatf("rd_b1_%0d", i), $signed(dst_d), pat(i));
    end
    dst_v = 1'b0; dst_last = 1'b0;
    chk("rd_bank_to0", integer'(rd_bank), 0);

    // Drain bank 0 while bank 1 commits on the same edge as dst_last
    for (int i = 0; i < 20; i++) begin
      dst_v = 1'b1; dst_a = AW'(i); dst_last = (i == 19);
      outr = (i >= 14) && (i <= 17); outrf = (i == 17);
      oa = AW'(i - 14); acc = 32'((100 + i) * 256);
      tick();
      chk($sformatf("rd_b0_%0d", i), $signed(dst_d), pat(20 + i));
    end
    dst_v = 1'b0; dst_last = 1'b0; outr = 1'b0; outrf = 1'b0;
    chk("same_edge_rd_bank", integer'(rd_bank), 1);
    chk("same_edge_wr_bank", integer'(wr_bank), 0);
    chk("same_edge_wr_ready", integer'(wr_ready), 1);
    chk("same_edge_rd_ready", integer'(rd_ready), 1);

    // Reset in the middle of a drain
    for (int i = 0; i < 2; i++) begin
      dst_v = 1'b1; dst_a = AW'(i);
      tick();
      chk($sformatf("rd_b1b_%0d", i), $signed(dst_d), 114 + i);
    end
    dst_a = AW'(2);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    dst_v = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      outr = 1'b1; outrf = (i == 2); oa = AW'(i); acc = 32'((i - 7) * 256);
      tick();
    end
    outr = 1'b0; outrf = 1'b0;
    tick();
    tick();
    chk("post_rst_rd_ready", integer'(rd_ready), 1);
    chk("post_rst_rd_bank", integer'(rd_bank), 0);
    chk("post_rst_wr_bank", integer'(wr_bank), 1);
    for (int i = 0; i < 3; i++) begin
      dst_v = 1'b1; dst_a = AW'(i); dst_last = (i == 2);
      tick();
      chk($sformatf("rd_post_%0d", i), $signed(dst_d), i - 7);
    end
    // Read of an EMPTY bank: zero data, valid, err
    dst_v = 1'b1; dst_a = '0; dst_last = 1'b0;
    tick();
    dst_v = 1'b0;
    chk("empty_rd_dv", integer'(dst_dv), 1);
    chk("empty_rd_d", integer'(dst_d), 0);
    chk("empty_rd_err", integer'(err), 1);
    tick();
    chk("idle_dv", integer'(dst_dv), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
